// File: rtl/arbiter_pkg.sv
// Shared encodings for the instruction/data read-port arbiter.
package arbiter_pkg;

    localparam int unsigned ST_W = 2;
    localparam int unsigned OWN_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_ADDR = 2'd1;
    localparam logic [ST_W-1:0] ST_DATA = 2'd2;

    // Owner codes double as the one-hot grant vector: bit 0 = ir, bit 1 = dr.
    localparam logic [OWN_W-1:0] OWN_NONE = 2'b00;
    localparam logic [OWN_W-1:0] OWN_IR   = 2'b01;
    localparam logic [OWN_W-1:0] OWN_DR   = 2'b10;

    localparam logic LAST_IR = 1'b0;
    localparam logic LAST_DR = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; the last-served flag is owned by the caller.
module rr_arb2
    import arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_i == LAST_DR) ? OWN_IR : OWN_DR;
        end
    end

endmodule

// File: rtl/read_port_arbiter.sv
// Shares one memory read port between the ir and dr channels with a single
// outstanding transaction and round-robin arbitration.
module read_port_arbiter
    import arbiter_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ir_addr_valid,
    output logic                 ir_addr_ready,
    input  logic [BUS_WIDTH-1:0] ir_addr,
    output logic                 ir_data_valid,
    input  logic                 ir_data_ready,
    output logic [BUS_WIDTH-1:0] ir_data,
    input  logic                 dr_addr_valid,
    output logic                 dr_addr_ready,
    input  logic [BUS_WIDTH-1:0] dr_addr,
    output logic                 dr_data_valid,
    input  logic                 dr_data_ready,
    output logic [BUS_WIDTH-1:0] dr_data,
    output logic                 mem_addr_valid,
    input  logic                 mem_addr_ready,
    output logic [BUS_WIDTH-1:0] mem_addr,
    input  logic                 mem_data_valid,
    output logic                 mem_data_ready,
    input  logic [BUS_WIDTH-1:0] mem_data,
    output logic [1:0]           grant
);

    logic [ST_W-1:0]      state_q, state_d;
    logic [BUS_WIDTH-1:0] addr_q, addr_d;
    logic [OWN_W-1:0]     owner_q, owner_d;
    logic                 last_q, last_d;
    logic [1:0]           pick;

    rr_arb2 u_rr_arb2 (
        .req_i  ({dr_addr_valid, ir_addr_valid}),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            owner_q <= OWN_NONE;
            last_q  <= LAST_DR;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Next-state and handshake/response routing.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        owner_d        = owner_q;
        last_d         = last_q;
        ir_addr_ready  = 1'b0;
        dr_addr_ready  = 1'b0;
        ir_data_valid  = 1'b0;
        dr_data_valid  = 1'b0;
        ir_data        = '0;
        dr_data        = '0;
        mem_addr_valid = 1'b0;
        mem_data_ready = 1'b0;
        mem_addr       = addr_q;

        case (state_q)
            ST_IDLE: begin
                ir_addr_ready = pick[0];
                dr_addr_ready = pick[1];
                if (pick != OWN_NONE) begin
                    addr_d  = pick[0] ? ir_addr : dr_addr;
                    owner_d = pick;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                mem_addr_valid = 1'b1;
                if (mem_addr_ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (owner_q == OWN_IR) begin
                    ir_data_valid  = mem_data_valid;
                    ir_data        = mem_data;
                    mem_data_ready = ir_data_ready;
                end else if (owner_q == OWN_DR) begin
                    dr_data_valid  = mem_data_valid;
                    dr_data        = mem_data;
                    mem_data_ready = dr_data_ready;
                end
                if (mem_data_valid && mem_data_ready) begin
                    last_d  = owner_q[1] ? LAST_DR : LAST_IR;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant = (state_q == ST_IDLE) ? OWN_NONE : owner_q;

endmodule

// File: tb/tb_read_port_arbiter.sv
// Directed and randomized checks of read_port_arbiter against a transaction-level model.
module tb_read_port_arbiter;

    localparam int unsigned BW = 32;
    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_IR   = 2'b01;
    localparam logic [1:0] G_DR   = 2'b10;

    logic          clk = 1'b0;
    logic          rst;
    logic          ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
    logic [BW-1:0] ir_addr, ir_data;
    logic          dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
    logic [BW-1:0] dr_addr, dr_data;
    logic          mem_addr_valid, mem_addr_ready, mem_data_valid, mem_data_ready;
    logic [BW-1:0] mem_addr, mem_data;
    logic [1:0]    grant;

    int unsigned total = 0;
    int unsigned bad = 0;

    read_port_arbiter #(.BUS_WIDTH(BW)) dut (
        .clk            (clk),
        .rst            (rst),
        .ir_addr_valid  (ir_addr_valid),
        .ir_addr_ready  (ir_addr_ready),
        .ir_addr        (ir_addr),
        .ir_data_valid  (ir_data_valid),
        .ir_data_ready  (ir_data_ready),
        .ir_data        (ir_data),
        .dr_addr_valid  (dr_addr_valid),
        .dr_addr_ready  (dr_addr_ready),
        .dr_addr        (dr_addr),
        .dr_data_valid  (dr_data_valid),
        .dr_data_ready  (dr_data_ready),
        .dr_data        (dr_data),
        .mem_addr_valid (mem_addr_valid),
        .mem_addr_ready (mem_addr_ready),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data_ready (mem_data_ready),
        .mem_data       (mem_data),
        .grant          (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Memory contents as a pure function of address.
    function automatic logic [BW-1:0] mem_fn(input logic [BW-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic drive_idle();
        ir_addr_valid  = 1'b0;
        ir_addr        = '0;
        ir_data_ready  = 1'b0;
        dr_addr_valid  = 1'b0;
        dr_addr        = '0;
        dr_data_ready  = 1'b0;
        mem_addr_ready = 1'b0;
        mem_data_valid = 1'b0;
        mem_data       = '0;
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 3 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]    exp_pick, exp_owner, last_srv;
        logic [BW-1:0] exp_addr, ir_next, dr_next, mem_word, exp_word;
        logic [BW-1:0] ir_sb[$];
        logic [BW-1:0] dr_sb[$];
        logic          mem_pend;
        int unsigned   hs, reads, cycles;

        rst = 1'b1;
        drive_idle();
        do_reset();

        // Reset state, with memory inputs active to expose leaks.
        mem_data_valid = 1'b1;
        mem_data       = 32'hFFFF_FFFF;
        ir_data_ready  = 1'b1;
        settle();
        check("rst_grant", grant, G_NONE);
        check("rst_mav", mem_addr_valid, 1'b0);
        check("rst_maddr", mem_addr, 32'h0);
        check("rst_ready", {dr_addr_ready, ir_addr_ready}, 2'b00);
        check("rst_dvalid", {dr_data_valid, ir_data_valid}, 2'b00);
        check("rst_ir_data", ir_data, 32'h0);
        check("rst_dr_data", dr_data, 32'h0);
        check("rst_mdr", mem_data_ready, 1'b0);

        // Single ir read with a zero-latency memory.
        tick();
        ir_addr_valid  = 1'b1;
        ir_addr        = 32'h100;
        mem_addr_ready = 1'b1;
        mem_data_valid = 1'b1;
        mem_data       = 32'hDEAD_BEEF;
        ir_data_ready  = 1'b1;
        dr_data_ready  = 1'b1;
        settle();
        check("s_ready", {dr_addr_ready, ir_addr_ready}, G_IR);
        check("s_grant0", grant, G_NONE);
        check("s_idle_dv", ir_data_valid, 1'b0);
        tick();
        ir_addr_valid = 1'b0;
        settle();
        check("s_mav", mem_addr_valid, 1'b1);
        check("s_maddr", mem_addr, 32'h100);
        check("s_grant1", grant, G_IR);
        tick();
        settle();
        check("s_dv", {dr_data_valid, ir_data_valid}, G_IR);
        check("s_data", ir_data, 32'hDEAD_BEEF);
        check("s_mdr", mem_data_ready, 1'b1);
        tick();
        settle();
        check("s_grant_end", grant, G_NONE);
        check("s_dv_end", ir_data_valid, 1'b0);

        // Tied requests after reset: ir first, then strict alternation.
        do_reset();
        ir_addr_valid  = 1'b1;
        ir_addr        = 32'h200;
        dr_addr_valid  = 1'b1;
        dr_addr        = 32'h8000;
        mem_addr_ready = 1'b1;
        mem_data_valid = 1'b1;
        mem_data       = 32'h1234_5678;
        ir_data_ready  = 1'b1;
        dr_data_ready  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            exp_pick = ((k / 3) % 2 == 0) ? G_IR : G_DR;
            settle();
            if (k % 3 == 0) begin
                check("tie_ready", {dr_addr_ready, ir_addr_ready}, exp_pick);
            end else if (k % 3 == 1) begin
                check("tie_grant", grant, exp_pick);
                check("tie_maddr", mem_addr, (exp_pick == G_IR) ? 32'h200 : 32'h8000);
            end else begin
                check("tie_dv", {dr_data_valid, ir_data_valid}, exp_pick);
            end
            tick();
        end

        // Memory stalls on both the address and data phases.
        do_reset();
        ir_addr_valid  = 1'b1;
        ir_addr        = 32'h300;
        dr_addr_valid  = 1'b1;
        dr_addr        = 32'h900;
        ir_data_ready  = 1'b1;
        dr_data_ready  = 1'b1;
        settle();
        check("st_ready", {dr_addr_ready, ir_addr_ready}, G_IR);
        tick();
        ir_addr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("st_mav", mem_addr_valid, 1'b1);
            check("st_maddr", mem_addr, 32'h300);
            check("st_noready_a", {dr_addr_ready, ir_addr_ready}, 2'b00);
            check("st_grant_a", grant, G_IR);
            tick();
        end
        mem_addr_ready = 1'b1;
        settle();
        check("st_maddr_hs", mem_addr, 32'h300);
        tick();
        mem_addr_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("st_dv_low", {dr_data_valid, ir_data_valid}, 2'b00);
            check("st_noready_d", {dr_addr_ready, ir_addr_ready}, 2'b00);
            check("st_grant_d", grant, G_IR);
            check("st_mav_d", mem_addr_valid, 1'b0);
            tick();
        end
        mem_data_valid = 1'b1;
        mem_data       = 32'hCAFE_0300;
        settle();
        check("st_dv", {dr_data_valid, ir_data_valid}, G_IR);
        check("st_data", ir_data, 32'hCAFE_0300);
        tick();
        mem_data_valid = 1'b0;
        settle();
        check("st_dr_next", {dr_addr_ready, ir_addr_ready}, G_DR);

        // Requester backpressure on dr.
        do_reset();
        dr_addr_valid  = 1'b1;
        dr_addr        = 32'h8000;
        mem_addr_ready = 1'b1;
        mem_data_valid = 1'b1;
        mem_data       = 32'hBEEF_8000;
        ir_data_ready  = 1'b1;
        dr_data_ready  = 1'b0;
        settle();
        check("bp_ready", {dr_addr_ready, ir_addr_ready}, G_DR);
        tick();
        dr_addr_valid = 1'b0;
        settle();
        check("bp_grant", grant, G_DR);
        tick();
        hs = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("bp_mdr_low", mem_data_ready, 1'b0);
            check("bp_dv", {dr_data_valid, ir_data_valid}, G_DR);
            check("bp_data", dr_data, 32'hBEEF_8000);
            if (mem_data_valid && mem_data_ready) hs++;
            tick();
        end
        dr_data_ready = 1'b1;
        settle();
        check("bp_mdr_high", mem_data_ready, 1'b1);
        if (mem_data_valid && mem_data_ready) hs++;
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            if (mem_data_valid && mem_data_ready) hs++;
        end
        check("bp_grant_end", grant, G_NONE);
        check("bp_dv_end", dr_data_valid, 1'b0);
        check("bp_hs", hs, 1);

        // Reset asserted for one cycle in the data phase.
        do_reset();
        ir_addr_valid  = 1'b1;
        ir_addr        = 32'h40;
        mem_addr_ready = 1'b1;
        ir_data_ready  = 1'b1;
        settle();
        check("rm_ready", ir_addr_ready, 1'b1);
        tick();
        ir_addr_valid = 1'b0;
        settle();
        tick();
        settle();
        check("rm_grant_data", grant, G_IR);
        rst            = 1'b1;
        mem_data_valid = 1'b1;
        ir_data_ready  = 1'b0;
        tick();
        rst = 1'b0;
        settle();
        check("rm_grant", grant, G_NONE);
        check("rm_mav", mem_addr_valid, 1'b0);
        check("rm_dv", {dr_data_valid, ir_data_valid}, 2'b00);
        check("rm_mdr", mem_data_ready, 1'b0);
        tick();
        mem_data_valid = 1'b0;
        ir_data_ready  = 1'b1;
        ir_addr_valid  = 1'b1;
        ir_addr        = 32'h400;
        settle();
        check("rm_new_ready", {dr_addr_ready, ir_addr_ready}, G_IR);
        tick();
        ir_addr_valid = 1'b0;
        settle();
        check("rm_new_maddr", mem_addr, 32'h400);
        tick();
        mem_data_valid = 1'b1;
        mem_data       = 32'h0400_ABCD;
        settle();
        check("rm_new_dv", ir_data_valid, 1'b1);
        check("rm_new_data", ir_data, 32'h0400_ABCD);
        tick();

        // Continuous dual traffic against a random-latency memory.
        do_reset();
        last_srv  = G_DR;
        exp_owner = G_NONE;
        exp_addr  = '0;
        mem_pend  = 1'b0;
        mem_word  = '0;
        ir_next   = $urandom;
        dr_next   = $urandom;
        reads     = 0;
        cycles    = 0;
        while (reads < 100 && cycles < 5000) begin
            ir_addr_valid  = 1'b1;
            ir_addr        = ir_next;
            dr_addr_valid  = 1'b1;
            dr_addr        = dr_next;
            mem_addr_ready = ($urandom % 3) != 0;
            if (mem_pend) begin
                mem_data_valid = mem_data_valid | (($urandom % 3) == 0);
                mem_data       = mem_word;
            end else begin
                mem_data_valid = 1'b0;
                mem_data       = $urandom;
            end
            ir_data_ready = ($urandom % 4) != 0;
            dr_data_ready = ($urandom % 4) != 0;
            settle();

            if (mem_pend) begin
                check("rnd_mdr", mem_data_ready, (exp_owner == G_IR) ? ir_data_ready : dr_data_ready);
                if (mem_data_valid && mem_data_ready) begin
                    check("rnd_dv", {dr_data_valid, ir_data_valid}, exp_owner);
                    if (exp_owner == G_IR) begin
                        exp_word = (ir_sb.size() > 0) ? ir_sb.pop_front() : 32'hXXXX_XXXX;
                        check("rnd_ir_data", ir_data, exp_word);
                    end else begin
                        exp_word = (dr_sb.size() > 0) ? dr_sb.pop_front() : 32'hXXXX_XXXX;
                        check("rnd_dr_data", dr_data, exp_word);
                    end
                    mem_pend = 1'b0;
                    last_srv = exp_owner;
                    reads++;
                end
            end

            if (ir_addr_ready || dr_addr_ready) begin
                exp_pick = (last_srv == G_IR) ? G_DR : G_IR;
                check("rnd_pick", {dr_addr_ready, ir_addr_ready}, exp_pick);
                exp_owner = exp_pick;
                if (exp_pick == G_IR) begin
                    exp_addr = ir_next;
                    ir_sb.push_back(mem_fn(ir_next));
                    ir_next = $urandom;
                end else begin
                    exp_addr = dr_next;
                    dr_sb.push_back(mem_fn(dr_next));
                    dr_next = $urandom;
                end
            end

            if (mem_addr_valid && mem_addr_ready) begin
                check("rnd_maddr", mem_addr, exp_addr);
                check("rnd_grant", grant, exp_owner);
                mem_pend = 1'b1;
                mem_word = mem_fn(mem_addr);
            end

            tick();
            cycles++;
        end
        if (reads < 100) begin
            check("rnd_timeout", reads, 100);
        end
        check("rnd_sb_left", ir_sb.size() + dr_sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/read_port_arbiter.md
# read_port_arbiter

Shares one memory read port between the core's instruction-read (ir_*) and data-read (dr_*) channels. It sits between `copperv` and the memory-side crossbar/memory model. It accepts one address handshake at a time, forwards it to the memory port, and routes the single response back to the requester that issued it. Arbitration is two-way round-robin, with one outstanding transaction.

## Interface
Parameters:
- BUS_WIDTH, 32, address/data width; equals `BUS_WIDTH` from copperv_h.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ir_addr_valid  in  1  instruction read request
- ir_addr_ready  out  1  instruction address accepted
- ir_addr  in  BUS_WIDTH  instruction read address
- ir_data_valid  out  1  instruction data valid
- ir_data_ready  in  1  core accepts instruction data
- ir_data  out  BUS_WIDTH  instruction read data
- dr_addr_valid, dr_addr_ready, dr_addr, dr_data_valid, dr_data_ready, dr_data: same as ir_*, for the data-read channel
- mem_addr_valid  out  1  memory read request
- mem_addr_ready  in  1  memory accepts address
- mem_addr  out  BUS_WIDTH  memory read address
- mem_data_valid  in  1  memory data valid
- mem_data_ready  out  1  arbiter accepts memory data
- mem_data  in  BUS_WIDTH  memory read data
- grant  out  2  owner of the current transaction: 00 none, 01 ir, 10 dr

## Operation
- FSM states: IDLE, ADDR, DATA.
- **IDLE**
  - Arbitrate combinationally among ir_addr_valid and dr_addr_valid.
  - If only one is valid, it wins.
  - If both are valid, the channel not served last wins. `last_q` resets to dr, so ir wins the first tie.
  - The winner's *_addr_ready is driven 1 in this same cycle and the handshake completes.
  - On that handshake: latch the address into addr_q, the winner into owner_q, and go to ADDR.
  - With no valid request, stay in IDLE; all ready/valid outputs are 0.
- **ADDR**
  - mem_addr_valid=1 and mem_addr=addr_q.
  - Hold until mem_addr_ready=1, then go to DATA.
  - Both *_addr_ready are 0.
- **DATA**
  - Combinational pass-through:
    - owner's *_data_valid = mem_data_valid
    - owner's *_data = mem_data
    - mem_data_ready = owner's *_data_ready
  - The non-owner's data_valid is 0; its data is don't-care (drive 0).
  - On mem_data_valid && mem_data_ready: last_q ← owner_q, go to IDLE.
- grant = owner_q during ADDR and DATA, 00 in IDLE.
- A requester that drops addr_valid before being granted loses nothing; no state is kept for it.
- A requester that keeps addr_valid high while the other channel is served stays pending and is granted next, because of round-robin.
- Address bits are not interpreted; no alignment checks.

## Timing
- Reset values:
  - state=IDLE, addr_q=0, owner_q=none, last_q=dr
  - all valid/ready outputs 0, mem_addr=0, grant=00, ir_data/dr_data=0
- Request seen in IDLE at cycle N: addr_ready=1 at N; mem_addr_valid=1 from N+1.
- If memory is ready at N+1, DATA starts at N+2. Response pass-through adds 0 cycles.
- Back-to-back minimum: one completed read every 3 cycles (IDLE, ADDR, DATA). The next addr_ready comes in the cycle after the data handshake.
- mem_addr and mem_addr_valid are stable while waiting for mem_addr_ready; they come from registers.
- A data backpressure stall (owner data_ready=0) holds DATA indefinitely.
- Reset mid-transaction (ADDR or DATA): return to IDLE next edge and abandon the transaction. The memory side shares rst and is reset with it.
- Both requesters valid in the same cycle: exactly one addr_ready is asserted, never both.

## Structure
- Shared package `arbiter_pkg` (alongside copperv_h): state encoding (IDLE=0, ADDR=1, DATA=2), owner encoding (NONE=00, IR=01, DR=10).
- Sub-module `rr_arb2`: 2-request round-robin pick from (req[1:0], last) → one-hot gnt. Purely combinational. last_q stays in the parent.
- Parent holds the FSM, addr_q, owner_q, last_q, and the response mux.

## Test plan
- **Single ir read:** ir_addr=0x100 in IDLE, memory returns 0xDEADBEEF with 0-cycle ready.
  - ir_addr_ready at cycle N; mem_addr=0x100 at N+1; ir_data_valid with 0xDEADBEEF at N+2.
  - dr_data_valid stays 0.
- **Simultaneous requests after reset:** ir 0x200 and dr 0x8000.
  - ir is granted first and dr second (grant 01 then 10).
  - Repeat the tie: ir is granted again only after dr has been served.
- **Memory stalls:** mem_addr_ready low 3 cycles, then mem_data_valid low 2 cycles.
  - mem_addr stays stable throughout; state holds; no spurious addr_ready.
- **Requester backpressure:** dr_data_ready=0 for 4 cycles while mem_data_valid=1.
  - mem_data_ready=0 until dr_data_ready rises; exactly one data handshake.
- **Reset mid-DATA:** rst=1 one cycle during DATA.
  - Next cycle state=IDLE, grant=00, all valids 0.
  - A new ir request is then served normally.
- **Continuous dual traffic for 100 reads with a random-latency memory model:**
  - Grants alternate strictly.
  - Every returned word matches the scoreboard for its channel's address.
